// File: rtl/mem_lsu.sv
// Memory stage: blocking single-outstanding loads plus a posted FIFO store buffer drained in the background.
// Optional store-to-load forwarding is enabled by defining MEM_LSU_STB_FWD_EN.
module mem_lsu #(
  parameter int AW        = 32,
  parameter int STB_DEPTH = 4,
  parameter int PTR_W     = $clog2(STB_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    ex_load_i,
  input  logic [1:0]    ex_store_i,
  input  logic [AW-1:0] ex_addr_i,
  input  logic [31:0]   ex_wdata_i,
  input  logic [4:0]    ex_wd_i,
  input  logic          ex_wreg_i,
  output logic          mem_stall_o,
  output logic [4:0]    wb_wd_o,
  output logic          wb_wreg_o,
  output logic [31:0]   wb_wdata_o,
  output logic          misalign_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [31:0]   bus_wdata_o,
  output logic [3:0]    bus_wstrb_o,
  input  logic          bus_gnt_i,
  input  logic          bus_rvalid_i,
  input  logic [31:0]   bus_rdata_i,
  output logic          stb_empty_o
);

  // state   | meaning
  // IDLE    | accept ops, drain store buffer
  // LD_REQ  | read request on the bus, waiting for gnt
  // LD_WAIT | read accepted, waiting for rvalid
  typedef enum logic [1:0] {IDLE, LD_REQ, LD_WAIT} state_t;

  localparam logic [2:0] OP_LB = 3'd1, OP_LH = 3'd2, OP_LW = 3'd3, OP_LBU = 3'd4, OP_LHU = 3'd5;
  localparam logic [1:0] OP_SB = 2'd1, OP_SH = 2'd2, OP_SW = 2'd3;

  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] ofs,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[7:0];
    case (ofs)
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = ofs[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LBU:  r = {24'd0, b};
      OP_LHU:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  state_t            state;
  logic [AW-1:0]     cap_addr;
  logic [2:0]        cap_op;
  logic [4:0]        cap_wd;
  logic              cap_wreg;

  logic [AW-3:0]     stb_addr [STB_DEPTH];
  logic [3:0]        stb_strb [STB_DEPTH];
  logic [31:0]       stb_data [STB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;

  logic ld_legal, ld_mis, st_mis, ld_valid, st_valid, misalign;
  logic full, may_issue, fwd_hit, issue, drain, push, pop;
  logic [3:0]  st_strb;
  logic [31:0] st_data, fwd_data;

  assign ld_legal = (ex_load_i >= OP_LB) && (ex_load_i <= OP_LHU);
  assign ld_mis   = ((ex_load_i == OP_LH || ex_load_i == OP_LHU) && ex_addr_i[0]) ||
                    (ex_load_i == OP_LW && ex_addr_i[1:0] != 2'd0);
  assign st_mis   = (ex_store_i == OP_SH && ex_addr_i[0]) ||
                    (ex_store_i == OP_SW && ex_addr_i[1:0] != 2'd0);
  assign ld_valid = ld_legal && !ld_mis;
  assign st_valid = (ex_store_i != 2'd0) && !st_mis;
  assign misalign = (ld_legal && ld_mis) || st_mis;
  assign full     = (count == (PTR_W+1)'(STB_DEPTH));

  always_comb begin
    st_strb = 4'b1111;
    st_data = ex_wdata_i;
    case (ex_store_i)
      OP_SB: begin
        st_strb = 4'b0001 << ex_addr_i[1:0];
        st_data = {4{ex_wdata_i[7:0]}};
      end
      OP_SH: begin
        st_strb = 4'b0011 << ex_addr_i[1:0];
        st_data = {2{ex_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_LSU_STB_FWD_EN
  logic [3:0]       ld_mask, fwd_strb;
  logic             any_match;
  logic [PTR_W-1:0] idx;

  always_comb begin
    case (ex_load_i)
      OP_LB, OP_LBU: ld_mask = 4'b0001 << ex_addr_i[1:0];
      OP_LH, OP_LHU: ld_mask = 4'b0011 << ex_addr_i[1:0];
      default:       ld_mask = 4'b1111;
    endcase
  end

  // Scan oldest to youngest so the last hit left standing is the youngest entry.
  always_comb begin
    any_match = 1'b0;
    fwd_strb  = 4'd0;
    fwd_data  = 32'd0;
    idx       = rd_ptr;
    for (int k = 0; k < STB_DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((PTR_W+1)'(k) < count && stb_addr[idx] == ex_addr_i[AW-1:2]) begin
        any_match = 1'b1;
        fwd_strb  = stb_strb[idx];
        fwd_data  = stb_data[idx];
      end
    end
  end

  assign may_issue = !any_match;
  assign fwd_hit   = ld_valid && any_match && ((fwd_strb & ld_mask) == ld_mask);
`else
  assign may_issue = (count == '0);
  assign fwd_hit   = 1'b0;
  assign fwd_data  = 32'd0;
`endif

  assign issue = (state == IDLE) && ld_valid && may_issue && !fwd_hit;
  assign drain = (state == IDLE) && (count != '0) && !issue;
  assign pop   = drain && bus_gnt_i;
  assign push  = (state == IDLE) && st_valid && (!full || pop);

  assign mem_stall_o = rst_n && (
      ((state == IDLE) && ((st_valid && full && !pop) || (ld_valid && !fwd_hit))) ||
      (state == LD_REQ) ||
      ((state == LD_WAIT) && !bus_rvalid_i));

  assign bus_req_o   = (state == LD_REQ) || drain;
  assign bus_we_o    = drain;
  assign bus_addr_o  = (state == LD_REQ) ? {cap_addr[AW-1:2], 2'b00} :
                       drain ? {stb_addr[rd_ptr], 2'b00} : '0;
  assign bus_wdata_o = drain ? stb_data[rd_ptr] : 32'd0;
  assign bus_wstrb_o = drain ? stb_strb[rd_ptr] : 4'd0;
  assign stb_empty_o = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      stb_addr[wr_ptr] <= ex_addr_i[AW-1:2];
      stb_strb[wr_ptr] <= st_strb;
      stb_data[wr_ptr] <= st_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cap_addr <= '0;
      cap_op   <= 3'd0;
      cap_wd   <= 5'd0;
      cap_wreg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          state    <= LD_REQ;
          cap_addr <= ex_addr_i;
          cap_op   <= ex_load_i;
          cap_wd   <= ex_wd_i;
          cap_wreg <= ex_wreg_i;
        end
        LD_REQ:  if (bus_gnt_i) state <= LD_WAIT;
        LD_WAIT: if (bus_rvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_wd_o    <= 5'd0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= 32'd0;
      misalign_o <= 1'b0;
    end else begin
      wb_wreg_o  <= 1'b0;
      misalign_o <= 1'b0;
      if (state == LD_WAIT && bus_rvalid_i) begin
        wb_wdata_o <= extract(cap_op, cap_addr[1:0], bus_rdata_i);
        wb_wd_o    <= cap_wd;
        wb_wreg_o  <= cap_wreg;
      end else if (state == IDLE && !mem_stall_o) begin
        wb_wd_o <= ex_wd_i;
        if (misalign) begin
          misalign_o <= 1'b1;
        end else if (fwd_hit) begin
          wb_wdata_o <= extract(ex_load_i, ex_addr_i[1:0], fwd_data);
          wb_wreg_o  <= ex_wreg_i;
        end else if (!st_valid) begin
          wb_wdata_o <= ex_wdata_i;
          wb_wreg_o  <= ex_wreg_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads, misalignment, store buffer fill/drain, reset, store/load ordering.
module tb_mem_lsu;
  logic        clk, rst_n;
  logic [2:0]  ex_load;
  logic [1:0]  ex_store;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic        mem_stall;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        misalign;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        stb_empty;
  int          n_run, n_fail;

  mem_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .ex_load_i(ex_load), .ex_store_i(ex_store), .ex_addr_i(ex_addr),
    .ex_wdata_i(ex_wdata), .ex_wd_i(ex_wd), .ex_wreg_i(ex_wreg),
    .mem_stall_o(mem_stall), .wb_wd_o(wb_wd), .wb_wreg_o(wb_wreg),
    .wb_wdata_o(wb_wdata), .misalign_o(misalign),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_wstrb_o(bus_wstrb),
    .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
    .stb_empty_o(stb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_load = 3'd0; ex_store = 2'd0; ex_addr = 32'd0;
    ex_wdata = 32'd0; ex_wd = 5'd0; ex_wreg = 1'b0;
  endtask

  // Load with gnt and rvalid each in their first cycle: WB lands 3 cycles after accept.
  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    ex_load = op; ex_addr = addr; ex_wd = 5'd7; ex_wreg = 1'b1;
    #1;
    chk({tag, "_accept_stall"}, mem_stall, 1);
    chk({tag, "_accept_noreq"}, bus_req, 0);
    cyc();
    bus_gnt = 1'b1;
    #1;
    chk({tag, "_req"}, bus_req, 1);
    chk({tag, "_req_we"}, bus_we, 0);
    chk({tag, "_req_addr"}, bus_addr, {addr[31:2], 2'b00});
    cyc();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rdata;
    #1;
    chk({tag, "_rvalid_nostall"}, mem_stall, 0);
    cyc();
    bus_rvalid = 1'b0;
    idle_in();
    #1;
    chk({tag, "_wdata"}, wb_wdata, exp);
    chk({tag, "_wreg"}, wb_wreg, 1);
    chk({tag, "_wd"}, wb_wd, 7);
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    rst_n = 1'b0;
    idle_in();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    #2;
    chk("rst_empty", stb_empty, 1);
    chk("rst_req", bus_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_wreg", wb_wreg, 0);
    chk("rst_wdata", wb_wdata, 0);
    chk("rst_misalign", misalign, 0);
    #10 rst_n = 1'b1;
    cyc();

    // non-memory op passes through with one cycle of latency
    ex_wdata = 32'h0000_1234; ex_wd = 5'd5; ex_wreg = 1'b1;
    #1;
    chk("alu_nostall", mem_stall, 0);
    cyc();
    idle_in();
    #1;
    chk("alu_wdata", wb_wdata, 32'h0000_1234);
    chk("alu_wd", wb_wd, 5);
    chk("alu_wreg", wb_wreg, 1);

    do_load("lb", 3'd1, 32'h103, 32'h80FF_FF00, 32'hFFFF_FF80);
    do_load("lbu", 3'd4, 32'h103, 32'h80FF_FF00, 32'h0000_0080);
    do_load("lh", 3'd2, 32'h102, 32'h8001_7FFF, 32'hFFFF_8001);

    // misaligned LW
    ex_load = 3'd3; ex_addr = 32'h102; ex_wreg = 1'b1; ex_wd = 5'd3;
    #1;
    chk("mis_nostall", mem_stall, 0);
    chk("mis_noreq", bus_req, 0);
    cyc();
    idle_in();
    #1;
    chk("mis_flag", misalign, 1);
    chk("mis_wreg", wb_wreg, 0);
    chk("mis_noreq2", bus_req, 0);
    cyc();
    chk("mis_oneshot", misalign, 0);

    // SH lane placement
    ex_store = 2'd2; ex_addr = 32'h202; ex_wdata = 32'h0000_ABCD; ex_wreg = 1'b0;
    #1;
    chk("sh_nostall", mem_stall, 0);
    cyc();
    idle_in();
    #1;
    chk("sh_wreg", wb_wreg, 0);
    chk("sh_req", bus_req, 1);
    chk("sh_we", bus_we, 1);
    chk("sh_addr", bus_addr, 32'h200);
    chk("sh_strb", bus_wstrb, 4'b1100);
    chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
    chk("sh_notempty", stb_empty, 0);
    bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0;
    #1;
    chk("sh_drained", stb_empty, 1);
    chk("sh_req_off", bus_req, 0);

    // fill the buffer with gnt low; fifth store stalls until a pop
    for (int i = 0; i < 4; i++) begin
      ex_store = 2'd3; ex_addr = 32'h300 + 32'(4 * i); ex_wdata = 32'h1000 + 32'(i);
      #1;
      chk("fill_nostall", mem_stall, 0);
      cyc();
    end
    ex_store = 2'd3; ex_addr = 32'h310; ex_wdata = 32'h1004;
    #1;
    chk("full_stall", mem_stall, 1);
    cyc();
    chk("full_stall_hold", mem_stall, 1);
    bus_gnt = 1'b1;
    #1;
    chk("full_pop_nostall", mem_stall, 0);
    chk("full_pop_addr", bus_addr, 32'h300);
    cyc();
    idle_in();
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("drain_addr", bus_addr, 32'h304 + 32'(4 * j));
      chk("drain_wdata", bus_wdata, 32'h1001 + 32'(j));
      chk("drain_strb", bus_wstrb, 4'b1111);
      chk("drain_we", bus_we, 1);
      cyc();
    end
    bus_gnt = 1'b0;
    #1;
    chk("drain_empty", stb_empty, 1);
    chk("drain_req_off", bus_req, 0);

    // SW pending, then LHU from the same word
    ex_store = 2'd3; ex_addr = 32'h40; ex_wdata = 32'h1234_5678;
    cyc();
    idle_in();
    ex_load = 3'd5; ex_addr = 32'h42; ex_wd = 5'd9; ex_wreg = 1'b1;
    #1;
`ifdef MEM_LSU_STB_FWD_EN
    chk("fwd_nostall", mem_stall, 0);
    chk("fwd_busdrain", bus_we, 1);
    cyc();
    idle_in();
    #1;
    chk("fwd_wdata", wb_wdata, 32'h0000_1234);
    chk("fwd_wreg", wb_wreg, 1);
    chk("fwd_pending", stb_empty, 0);
    bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0;
    #1;
    chk("fwd_drained", stb_empty, 1);
`else
    chk("ord_stall", mem_stall, 1);
    chk("ord_drain_we", bus_we, 1);
    chk("ord_drain_addr", bus_addr, 32'h40);
    bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0;
    #1;
    chk("ord_empty", stb_empty, 1);
    chk("ord_stall2", mem_stall, 1);
    chk("ord_noreq", bus_req, 0);
    cyc();
    bus_gnt = 1'b1;
    #1;
    chk("ord_rd_req", bus_req, 1);
    chk("ord_rd_we", bus_we, 0);
    chk("ord_rd_addr", bus_addr, 32'h40);
    cyc();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    #1;
    chk("ord_rv_nostall", mem_stall, 0);
    cyc();
    bus_rvalid = 1'b0;
    idle_in();
    #1;
    chk("ord_wdata", wb_wdata, 32'h0000_1234);
    chk("ord_wreg", wb_wreg, 1);
    chk("ord_wd", wb_wd, 9);
`endif

    // reset while draining: request drops without a clock edge
    ex_store = 2'd3; ex_addr = 32'h500; ex_wdata = 32'hCAFE;
    cyc();
    idle_in();
    #1;
    chk("rst_drain_req", bus_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_drain_req_off", bus_req, 0);
    chk("rst_drain_empty", stb_empty, 1);
    #3 rst_n = 1'b1;
    cyc();

    // reset while a load waits for rvalid; the late rvalid must be ignored
    ex_load = 3'd3; ex_addr = 32'h100; ex_wd = 5'd4; ex_wreg = 1'b1;
    cyc();
    bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0;
    #1;
    chk("rst_ld_wait_stall", mem_stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_ld_stall", mem_stall, 0);
    chk("rst_ld_req", bus_req, 0);
    chk("rst_ld_empty", stb_empty, 1);
    chk("rst_ld_wreg", wb_wreg, 0);
    #1 rst_n = 1'b1;
    idle_in();
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    cyc();
    bus_rvalid = 1'b0;
    #1;
    chk("late_rv_wreg", wb_wreg, 0);
    chk("late_rv_wdata", wb_wdata, 0);
    chk("late_rv_req", bus_req, 0);
    chk("late_rv_stall", mem_stall, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Parametrised successor to the single-request memory stage: sits between EX and WB and owns the data-memory bus port.
- Loads: blocking, single-outstanding, with byte/half/word sign- or zero-extension.
- Stores: posted into a STB_DEPTH-entry FIFO store buffer and drained to the bus in the background, so stores stall only when the buffer is full.

Parameters:
- AW, 32: byte address width.
- STB_DEPTH, 4: store buffer entries; power of two, >=2.
- PTR_W, $clog2(STB_DEPTH): pointer width, derived.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_load_i  in  3  load op: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6/7 illegal, treated as none.
- ex_store_i  in  2  store op: 0 none, 1 SB, 2 SH, 3 SW.
- ex_addr_i  in  AW  effective address.
- ex_wdata_i  in  32  store data, or ALU result for non-memory ops.
- ex_wd_i  in  5  destination register.
- ex_wreg_i  in  1  register write enable.
- mem_stall_o  out  1  hold EX/earlier stages; ex_* held stable while high.
- wb_wd_o  out  5  WB destination register.
- wb_wreg_o  out  1  WB write enable.
- wb_wdata_o  out  32  WB data.
- misalign_o  out  1  one-cycle misaligned-access flag.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  AW  word-aligned address (low 2 bits 0).
- bus_wdata_o  out  32  lane-aligned write data.
- bus_wstrb_o  out  4  byte strobes.
- bus_gnt_i  in  1  request accepted this cycle.
- bus_rvalid_i  in  1  read data valid.
- bus_rdata_i  in  32  read data.
- stb_empty_o  out  1  store buffer empty (fence support).

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, except stb_empty_o=1.
  - FSM to IDLE; buffer pointers and count cleared; pending entries discarded.
  - bus_req_o drops immediately, without waiting for the clock.
- Non-memory op (load=0, store=0):
  - wb_* registered from ex_*: 1-cycle latency; no stall.
- Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
  - Next cycle: misalign_o=1 and wb_wreg_o=0.
  - No bus access, no buffer entry, no stall.
- Store, buffer not full:
  - Accepted in the presented cycle.
  - Entry holds word address, wstrb (SB 0001<<a[1:0], SH 0011<<a[1:0], SW 1111) and data replicated into all lanes.
  - Next cycle wb_wreg_o=0.
- Store, buffer full:
  - mem_stall_o=1 combinationally until a pop occurs.
  - A pop (drain gnt) and a push in the same cycle are both legal; count is unchanged.
- Drain:
  - When FSM=IDLE, buffer non-empty and no load is presented: bus_req_o=1, bus_we_o=1, driven from the head entry.
  - Head popped on the cycle bus_gnt_i=1; bus_req_o stays high while entries remain (back-to-back).
  - A presented load takes priority only when it can issue (see below).
- Load FSM: IDLE -> LD_REQ -> LD_WAIT -> IDLE.
  - IDLE, load presented:
    - mem_stall_o=1.
    - If the load may issue (no STB conflict), go to LD_REQ next cycle.
    - Otherwise stay in IDLE while drain continues.
  - LD_REQ:
    - bus_req_o=1, bus_we_o=0, bus_addr_o={addr[AW-1:2],2'b00}.
    - Stay until bus_gnt_i; then go to LD_WAIT.
  - LD_WAIT:
    - Wait for bus_rvalid_i.
    - In the rvalid cycle, mem_stall_o=0 combinationally.
    - Next cycle: wb_wdata_o = extracted lane, sign- or zero-extended; wb_wd_o/wb_wreg_o from the captured request.
    - Return to IDLE.
  - Minimum load latency: accept cycle 0, req cycle 1 with gnt, rvalid cycle 2, WB cycle 3.
- Default conflict rule: a load issues only when stb_empty_o=1, giving strict program order.
- bus_rvalid_i outside LD_WAIT: ignored.
- bus_gnt_i without bus_req_o: ignored.

Optional Feature:
- Macro: MEM_LSU_STB_FWD_EN.
- Defined:
  - A load compares its word address against all valid entries.
  - No match: issues immediately, regardless of buffer occupancy.
  - Youngest matching entry's wstrb covers all load bytes: data forwarded from that entry; no bus access; WB next cycle (1-cycle load).
  - Partial overlap, or an older matching entry partly covered by the youngest: stall until no matching entries remain.
- Undefined: default conflict rule (load waits for empty buffer); no comparators synthesised.

Test Plan:
- Reset mid-load: rst_n low during LD_WAIT -> bus_req_o=0 immediately; stb_empty_o=1; wb_wreg_o=0; a late rvalid is ignored.
- LB at 0x103, rdata=0x80FF_FF00 -> wb_wdata_o=0xFFFF_FF80; LBU at the same address -> 0x0000_0080; WB 3 cycles after accept with gnt and rvalid each in their first cycle.
- 5 back-to-back SW with STB_DEPTH=4, gnt held low -> 5th store stalls; one gnt -> 5th is accepted in the same cycle as the pop; 4 writes then issue in FIFO order with strobes 1111.
- SH 0xABCD to 0x202 -> bus_wstrb_o=1100, bus_wdata_o=0xABCD_ABCD, bus_addr_o=0x200.
- LW 0x102 -> misalign_o=1 for one cycle; no bus_req_o; no stall.
- FWD_EN: SW 0x1234_5678 to 0x40 pending, then LHU 0x42 -> wb_wdata_o=0x0000_1234 with no bus read; without FWD_EN the load waits for the drain gnt, then reads from the bus.
